// File: rtl/alu_seq_responder.sv
// Sequential handshaked ALU responder: accepts one {op1, op2, oprn}
// request, executes it (single cycle, or iterative shift-add for multiply),
// and holds {result, err} until the consumer takes it.
module alu_seq_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);

  // Counter must reach DATA_WIDTH itself: DATA_WIDTH shift-add steps
  // followed by one cycle that publishes the accumulator.
  localparam int                    CNT_W       = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]      MUL_LAST    = CNT_W'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SHAMT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;

  // During MUL, r_op1 doubles as the shifting multiplicand and r_op2 as
  // the shifting multiplier, so no extra operand copies are needed.
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [OPRN_WIDTH-1:0] r_oprn;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_exec_result;
  logic                  w_exec_err;
  logic [DATA_WIDTH-1:0] w_add_term;

  // State register; reset from any state returns to IDLE and drops any response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; in_ready only in IDLE, out_valid only in DONE.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (oprn == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        w_state_next = DONE;
      end
      MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Single-cycle operations evaluated from the registered operands.
  always_comb begin
    w_exec_result = '0;
    w_exec_err    = 1'b0;
    case (r_oprn)
      OP_ADD: w_exec_result = r_op1 + r_op2;
      OP_SUB: w_exec_result = r_op1 - r_op2;
      OP_SRL: w_exec_result = (r_op2 >= SHAMT_LIMIT) ? '0 : (r_op1 >> r_op2);
      OP_SLL: w_exec_result = (r_op2 >= SHAMT_LIMIT) ? '0 : (r_op1 << r_op2);
      OP_AND: w_exec_result = r_op1 & r_op2;
      OP_OR:  w_exec_result = r_op1 | r_op2;
      OP_NOR: w_exec_result = ~(r_op1 | r_op2);
      OP_SLT: w_exec_result = {{(DATA_WIDTH-1){1'b0}}, (r_op1 < r_op2)};
      default: begin
        // Unsupported opcode (0x03 never reaches EXEC).
        w_exec_result = '0;
        w_exec_err    = 1'b1;
      end
    endcase
  end

  // Partial product for the current multiplier bit.
  always_comb begin
    w_add_term = r_op2[0] ? r_op1 : '0;
  end

  // Operand capture, iterative multiply and result holding register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_oprn   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op1  <= op1;
            r_op2  <= op2;
            r_oprn <= oprn;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        EXEC: begin
          r_result <= w_exec_result;
          r_err    <= w_exec_err;
        end
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            // Low word only; matches two's-complement product for signed inputs.
            r_result <= r_acc;
            r_err    <= 1'b0;
          end else begin
            r_acc <= r_acc + w_add_term;
            r_op1 <= r_op1 << 1;
            r_op2 <= r_op2 >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // DONE: hold result/err until the consumer takes them.
        end
      endcase
    end
  end

  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Scoreboard bench for alu_seq_responder: the driver pushes expected
// responses, a forked monitor pops and checks them at each handshake.
module tb_alu_seq_responder;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  oprn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] exp_q[$];

  alu_seq_responder #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .oprn      (oprn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, expv);
    end
  endtask

  // Pops one expected response per handshake (sampled on the falling edge).
  task automatic monitor_loop();
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("resp result=0x%08h err=%0d exp_result=0x%08h exp_err=%0d",
                   result, err, e[31:0], e[32]);
          check("resp_result", result, e[31:0]);
          check("resp_err", {31'd0, err}, {31'd0, e[32]});
        end
      end
    end
  endtask

  // Issues one request, checks latency (and in_ready low while busy),
  // then completes the handshake if requested.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                      input logic [31:0] exp_res, input logic exp_err,
                      input int exp_lat, input bit do_hs);
    int guard;
    int lat;
    logic busy_ready;
    in_valid = 1'b1;
    op1      = a;
    op2      = b;
    oprn     = op;
    exp_q.push_back({exp_err, exp_res});
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    check("accept_wait", (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
    @(posedge CLK); #1;          // accept edge
    in_valid   = 1'b0;
    op1        = $urandom;       // junk after accept must be ignored
    op2        = $urandom;
    oprn       = 6'($urandom);
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
    if (in_ready) busy_ready = 1'b1;
    $display("req op=0x%02h a=0x%08h b=0x%08h latency=%0d", op, a, b, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    check("in_ready_busy", {31'd0, busy_ready}, 32'd0);
    if (do_hs) begin
      @(posedge CLK); #1;        // handshake edge (out_ready high)
      check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    RST       = 1'b1;
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    oprn      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Arithmetic, multiply, shifts, logic, compare, errors.
    send(32'd15,          32'd3,          6'h01, 32'd18,         1'b0, 2,  1'b1);
    send(-32'sd15,        -32'sd5,        6'h01, 32'hFFFFFFEC,   1'b0, 2,  1'b1);
    send(-32'sd15,        32'd5,          6'h02, 32'hFFFFFFEC,   1'b0, 2,  1'b1);
    send(32'd15,          -32'sd5,        6'h03, 32'hFFFFFFB5,   1'b0, 34, 1'b1);
    send(32'd7,           32'd6,          6'h03, 32'd42,         1'b0, 34, 1'b1);
    send(32'd15,          32'd2,          6'h04, 32'd3,          1'b0, 2,  1'b1);
    send(32'd15,          32'd4,          6'h05, 32'd240,        1'b0, 2,  1'b1);
    send(32'd15,          32'd32,         6'h05, 32'd0,          1'b0, 2,  1'b1);
    send(32'h80000000,    32'd31,         6'h04, 32'd1,          1'b0, 2,  1'b1);
    send(32'd15,          32'd8,          6'h06, 32'd8,          1'b0, 2,  1'b1);
    send(32'd15,          32'd8,          6'h07, 32'd15,         1'b0, 2,  1'b1);
    send(32'd15,          32'd8,          6'h08, 32'hFFFFFFF0,   1'b0, 2,  1'b1);
    send(32'd15,          32'd8,          6'h09, 32'd0,          1'b0, 2,  1'b1);
    send(32'd0,           32'd1,          6'h09, 32'd1,          1'b0, 2,  1'b1);
    send(32'd5,           32'd6,          6'h0A, 32'd0,          1'b1, 2,  1'b1);
    send(32'd5,           32'd6,          6'h00, 32'd0,          1'b1, 2,  1'b1);
    send(32'd5,           32'd6,          6'h3F, 32'd0,          1'b1, 2,  1'b1);
    check("result_held_idle", result, 32'd0);

    // Backpressure: response held for 5 cycles, new request ignored.
    out_ready = 1'b0;
    send(32'd7, 32'd9, 6'h01, 32'd16, 1'b0, 2, 1'b0);
    in_valid = 1'b1;
    op1      = 32'd1;
    op2      = 32'd1;
    oprn     = 6'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("bp_result", result, 32'd16);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a multiply: response must never appear.
    in_valid = 1'b1;
    op1      = 32'd3;
    op2      = 32'd4;
    oprn     = 6'h03;
    @(posedge CLK); #1;          // accepted (unit is idle)
    in_valid = 1'b0;
    check("midrst_busy", {31'd0, in_ready}, 32'd0);
    repeat (9) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (50) begin
        @(posedge CLK); #1;
        if (out_valid) seen = 1'b1;
      end
      check("midrst_no_response", {31'd0, seen}, 32'd0);
    end

    // Unit still works after the abort.
    send(32'd100, 32'd23, 6'h02, 32'd77, 1'b0, 2, 1'b1);

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
